// File: rtl/target_feeder_pkg.sv
// Shared definitions for the target feeder and the scoring array.
// Base codes, slot states and the default score width.
package target_feeder_pkg;

    localparam int SCORE_WIDTH_DEFAULT = 12;

    localparam logic [1:0] BASE_T = 2'b00;
    localparam logic [1:0] BASE_C = 2'b01;
    localparam logic [1:0] BASE_A = 2'b10;
    localparam logic [1:0] BASE_G = 2'b11;

    typedef enum logic [2:0] {
        SLOT_EMPTY,
        SLOT_LOADING,
        SLOT_STREAMING,
        SLOT_WAIT,
        SLOT_RESULT
    } slot_state_e;

endpackage

// File: rtl/feeder_slot.sv
// One target slot: base buffer, write/read pointers, state machine,
// WAIT timeout counter and score capture.
module feeder_slot
    import target_feeder_pkg::*;
#(
    parameter int SCORE_WIDTH = SCORE_WIDTH_DEFAULT,
    parameter int MAX_LEN     = 1024,
    parameter int TIMEOUT     = 264
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [1:0]             wr_base,
    input  logic                   wr_last,
    input  logic                   rd_en,
    input  logic                   vld,
    input  logic [SCORE_WIDTH-1:0] result,
    input  logic                   res_ack,
    output logic                   accepting,
    output logic                   streaming,
    output logic                   has_result,
    output logic [1:0]             rd_data,
    output logic [SCORE_WIDTH-1:0] score,
    output logic                   timeout
);

    localparam int PW = $clog2(MAX_LEN) + 1;
    localparam int AW = $clog2(MAX_LEN);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(MAX_LEN - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    slot_state_e state_q, state_d;
    logic [PW-1:0] len_q, len_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SCORE_WIDTH-1:0] score_q, score_d;
    logic tmo_q, tmo_d;
    logic [1:0] mem_q [MAX_LEN];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[len_q[AW-1:0]] <= wr_base;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= SLOT_EMPTY;
            len_q   <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            score_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        rp_d    = rp_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            SLOT_EMPTY, SLOT_LOADING: begin
                if (wr_en) begin
                    len_d   = len_q + PW'(1);
                    state_d = SLOT_LOADING;
                    // a full buffer acts as an implicit last base
                    if (wr_last || len_q == LAST_IDX) begin
                        state_d = SLOT_STREAMING;
                        rp_d    = '0;
                    end
                end
            end
            SLOT_STREAMING: begin
                if (rd_en) begin
                    rp_d = rp_q + PW'(1);
                    if (rp_q == len_q - PW'(1)) begin
                        state_d = SLOT_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            SLOT_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (vld) begin
                    score_d = result;
                    tmo_d   = 1'b0;
                    state_d = SLOT_RESULT;
                end else if (cnt_q == CNT_LAST) begin
                    score_d = '0;
                    tmo_d   = 1'b1;
                    state_d = SLOT_RESULT;
                end
            end
            SLOT_RESULT: begin
                if (res_ack) begin
                    state_d = SLOT_EMPTY;
                    len_d   = '0;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    assign accepting  = (state_q == SLOT_EMPTY) || (state_q == SLOT_LOADING);
    assign streaming  = (state_q == SLOT_STREAMING);
    assign has_result = (state_q == SLOT_RESULT);
    assign rd_data    = mem_q[rp_q[AW-1:0]];
    assign score      = score_q;
    assign timeout    = tmo_q;

endmodule

// File: rtl/target_feeder.sv
// Two-slot target streamer for the systolic scoring array:
// interleaved base feed plus a slot-0-first result arbiter.
module target_feeder
    import target_feeder_pkg::*;
#(
    parameter int SCORE_WIDTH = SCORE_WIDTH_DEFAULT,
    parameter int LENGTH      = 128,
    parameter int MAX_LEN     = 1024,
    parameter int TIMEOUT     = 2 * LENGTH + 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic                   wr_slot,
    input  logic [1:0]             wr_base,
    input  logic                   wr_last,
    input  logic                   sm_toggle,
    input  logic                   sm_vld0,
    input  logic                   sm_vld1,
    input  logic [SCORE_WIDTH-1:0] sm_result,
    output logic                   sm_en0,
    output logic                   sm_en1,
    output logic [1:0]             sm_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_slot,
    output logic [SCORE_WIDTH-1:0] res_score,
    output logic                   res_timeout
);

    logic acc0, acc1, str0, str1, res0, res1;
    logic to0, to1, ack0, ack1, we0, we1;
    logic [1:0] d0, d1;
    logic [SCORE_WIDTH-1:0] sc0, sc1;

    assign wr_ready = rst & (wr_slot ? acc1 : acc0);
    assign we0 = wr_valid & wr_ready & ~wr_slot;
    assign we1 = wr_valid & wr_ready & wr_slot;

    assign sm_en0 = str0 & ~sm_toggle;
    assign sm_en1 = str1 & sm_toggle;

    assign ack0 = res_ready & res0;
    assign ack1 = res_ready & res1 & ~res0;

    feeder_slot #(
        .SCORE_WIDTH(SCORE_WIDTH),
        .MAX_LEN    (MAX_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (we0),
        .wr_base   (wr_base),
        .wr_last   (wr_last),
        .rd_en     (sm_en0),
        .vld       (sm_vld0),
        .result    (sm_result),
        .res_ack   (ack0),
        .accepting (acc0),
        .streaming (str0),
        .has_result(res0),
        .rd_data   (d0),
        .score     (sc0),
        .timeout   (to0)
    );

    feeder_slot #(
        .SCORE_WIDTH(SCORE_WIDTH),
        .MAX_LEN    (MAX_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (we1),
        .wr_base   (wr_base),
        .wr_last   (wr_last),
        .rd_en     (sm_en1),
        .vld       (sm_vld1),
        .result    (sm_result),
        .res_ack   (ack1),
        .accepting (acc1),
        .streaming (str1),
        .has_result(res1),
        .rd_data   (d1),
        .score     (sc1),
        .timeout   (to1)
    );

    always_comb begin
        sm_data = BASE_T;
        if (sm_en1) begin
            sm_data = d1;
        end else if (sm_en0) begin
            sm_data = d0;
        end
    end

    always_comb begin
        res_valid   = 1'b0;
        res_slot    = 1'b0;
        res_score   = '0;
        res_timeout = 1'b0;
        if (res0) begin
            res_valid   = 1'b1;
            res_score   = sc0;
            res_timeout = to0;
        end else if (res1) begin
            res_valid   = 1'b1;
            res_slot    = 1'b1;
            res_score   = sc1;
            res_timeout = to1;
        end
    end

endmodule

// File: tb/tb_target_feeder.sv
// Self-checking bench for target_feeder: directed scenarios plus random
// traffic, all checked every cycle against a queue-based reference model.
module tb_target_feeder;
    import target_feeder_pkg::*;

    localparam int SW      = 12;
    localparam int LENGTH  = 8;
    localparam int MAX_LEN = 8;
    localparam int TIMEOUT = 2 * LENGTH + 8;

    localparam int P_FILL = 0;
    localparam int P_FEED = 1;
    localparam int P_HOLD = 2;
    localparam int P_DONE = 3;

    logic clk = 1'b0;
    logic rst;
    logic wr_valid, wr_ready, wr_slot, wr_last;
    logic [1:0] wr_base;
    logic sm_toggle, sm_vld0, sm_vld1;
    logic [SW-1:0] sm_result;
    logic sm_en0, sm_en1;
    logic [1:0] sm_data;
    logic res_valid, res_ready, res_slot, res_timeout;
    logic [SW-1:0] res_score;

    target_feeder #(
        .SCORE_WIDTH(SW),
        .LENGTH     (LENGTH),
        .MAX_LEN    (MAX_LEN),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_slot    (wr_slot),
        .wr_base    (wr_base),
        .wr_last    (wr_last),
        .sm_toggle  (sm_toggle),
        .sm_vld0    (sm_vld0),
        .sm_vld1    (sm_vld1),
        .sm_result  (sm_result),
        .sm_en0     (sm_en0),
        .sm_en1     (sm_en1),
        .sm_data    (sm_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_slot   (res_slot),
        .res_score  (res_score),
        .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int obs_en0 = 0;
    int obs_en1 = 0;

    // reference model: phase per slot, base queue, wait start, captured result
    int ph [2];
    logic [1:0] fq [2][$];
    int hold_at [2];
    logic [SW-1:0] m_score [2];
    logic m_to [2];
    int cyc = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare();
        logic xe0, xe1, xv, xs, xt;
        logic [1:0] xd;
        logic [SW-1:0] xsc;
        xe0 = (ph[0] == P_FEED) && !sm_toggle;
        xe1 = (ph[1] == P_FEED) && sm_toggle;
        xd = 2'b00;
        if (xe0) xd = fq[0][0];
        if (xe1) xd = fq[1][0];
        xv = (ph[0] == P_DONE) || (ph[1] == P_DONE);
        xs = 1'b0;
        xsc = '0;
        xt = 1'b0;
        if (ph[0] == P_DONE) begin
            xsc = m_score[0];
            xt = m_to[0];
        end else if (ph[1] == P_DONE) begin
            xs = 1'b1;
            xsc = m_score[1];
            xt = m_to[1];
        end
        check("wr_ready", 32'(wr_ready), 32'(rst && ph[wr_slot] == P_FILL));
        check("sm_en0", 32'(sm_en0), 32'(xe0));
        check("sm_en1", 32'(sm_en1), 32'(xe1));
        check("sm_data", 32'(sm_data), 32'(xd));
        check("res_valid", 32'(res_valid), 32'(xv));
        check("res_slot", 32'(res_slot), 32'(xs));
        check("res_score", 32'(res_score), 32'(xsc));
        check("res_timeout", 32'(res_timeout), 32'(xt));
        if (sm_en0) obs_en0++;
        if (sm_en1) obs_en1++;
    endtask

    task automatic model_edge();
        logic en [2];
        logic ack [2];
        logic v;
        cyc++;
        if (!rst) begin
            for (int s = 0; s < 2; s++) begin
                ph[s] = P_FILL;
                fq[s].delete();
            end
            return;
        end
        en[0] = (ph[0] == P_FEED) && !sm_toggle;
        en[1] = (ph[1] == P_FEED) && sm_toggle;
        ack[0] = res_ready && ph[0] == P_DONE;
        ack[1] = res_ready && ph[1] == P_DONE && ph[0] != P_DONE;
        for (int s = 0; s < 2; s++) begin
            v = (s == 0) ? sm_vld0 : sm_vld1;
            case (ph[s])
                P_FILL: if (wr_valid && wr_slot == 1'(s)) begin
                    fq[s].push_back(wr_base);
                    if (wr_last || fq[s].size() == MAX_LEN) ph[s] = P_FEED;
                end
                P_FEED: if (en[s]) begin
                    void'(fq[s].pop_front());
                    if (fq[s].size() == 0) begin
                        ph[s] = P_HOLD;
                        hold_at[s] = cyc;
                    end
                end
                P_HOLD: if (v) begin
                    m_score[s] = sm_result;
                    m_to[s] = 1'b0;
                    ph[s] = P_DONE;
                end else if (cyc - hold_at[s] == TIMEOUT) begin
                    m_score[s] = '0;
                    m_to[s] = 1'b1;
                    ph[s] = P_DONE;
                end
                default: if (ack[s]) ph[s] = P_FILL;
            endcase
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid = 0; wr_slot = 0; wr_base = 0; wr_last = 0;
        sm_vld0 = 0; sm_vld1 = 0; sm_result = 0; res_ready = 0;
    endtask

    task automatic write(input logic s, input logic [1:0] b, input logic l);
        wr_valid = 1; wr_slot = s; wr_base = b; wr_last = l;
        sm_toggle = ~sm_toggle;
        step();
        wr_valid = 0; wr_last = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            sm_toggle = ~sm_toggle;
            step();
        end
    endtask

    initial begin
        logic [1:0] seq [4];
        seq[0] = BASE_A; seq[1] = BASE_C; seq[2] = BASE_G; seq[3] = BASE_T;
        for (int s = 0; s < 2; s++) begin
            ph[s] = P_FILL; hold_at[s] = 0; m_score[s] = '0; m_to[s] = 1'b0;
        end
        idle_inputs();
        sm_toggle = 1;
        rst = 0;
        @(posedge clk);
        model_edge();
        #1;
        step();
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        rst = 1;
        #1;
        check("post_rst_wr_ready", 32'(wr_ready), 32'd1);

        // single slot: A,C,G,T then score 0x80A
        obs_en0 = 0; obs_en1 = 0;
        for (int i = 0; i < 4; i++) write(1'b0, seq[i], i == 3);
        run(10);
        check("single_en0_count", 32'(obs_en0), 32'd4);
        check("single_en1_count", 32'(obs_en1), 32'd0);
        sm_vld0 = 1; sm_result = 12'h80A;
        step();
        sm_vld0 = 0;
        check("single_valid", 32'(res_valid), 32'd1);
        check("single_score", 32'(res_score), 32'h80A);
        res_ready = 1; step(); res_ready = 0;

        // interleave 3 + 5 bases, shared score, backpressure
        obs_en0 = 0; obs_en1 = 0;
        for (int i = 0; i < 3; i++) write(1'b0, 2'($urandom), i == 2);
        for (int i = 0; i < 5; i++) write(1'b1, 2'($urandom), i == 4);
        run(12);
        check("ilv_en0_count", 32'(obs_en0), 32'd3);
        check("ilv_en1_count", 32'(obs_en1), 32'd5);
        sm_vld0 = 1; sm_vld1 = 1; sm_result = 12'h815;
        step();
        sm_vld0 = 0; sm_vld1 = 0;
        run(5);
        check("arb_slot0", 32'(res_slot), 32'd0);
        res_ready = 1; step();
        check("arb_slot1", 32'(res_slot), 32'd1);
        check("arb_score1", 32'(res_score), 32'h815);
        step(); res_ready = 0;

        // timeout
        write(1'b0, BASE_G, 1'b0);
        write(1'b0, BASE_C, 1'b1);
        run(TIMEOUT + 10);
        check("tmo_flag", 32'(res_timeout), 32'd1);
        check("tmo_score", 32'(res_score), 32'd0);
        res_ready = 1; step(); res_ready = 0;

        // full buffer without last, then reset mid-stream
        sm_toggle = 0;
        for (int i = 0; i < MAX_LEN; i++) begin
            wr_valid = 1; wr_slot = 0; wr_base = 2'($urandom); sm_toggle = 1;
            step();
        end
        wr_valid = 0;
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        run(6);
        rst = 0; sm_toggle = 0;
        step();
        check("rst_mid_en0", 32'(sm_en0), 32'd0);
        rst = 1;
        run(40);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 299) != 0);
            wr_valid  = ($urandom_range(0, 9) < 6);
            wr_slot   = 1'($urandom);
            wr_base   = 2'($urandom);
            wr_last   = ($urandom_range(0, 4) == 0);
            sm_toggle = 1'($urandom);
            sm_vld0   = ($urandom_range(0, 19) == 0);
            sm_vld1   = ($urandom_range(0, 19) == 0);
            sm_result = SW'($urandom);
            res_ready = 1'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
